// File: rtl/isect_sched.sv
// isect_sched: runs one ray against a contiguous triangle range.
// Issues one triangle read per cycle, delays the read strobe by the
// memory latency to enable the intersection unit, counts in-order returns
// and keeps the closest hit (smallest signed t, earliest index on ties).
module isect_sched #(
    parameter int IDX_W   = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_ray_valid,
    output logic                    o_ray_ready,
    input  logic [0:1][0:2][31:0]   i_ray,
    input  logic [IDX_W-1:0]        i_base,
    input  logic [IDX_W-1:0]        i_count,
    output logic                    o_mem_rd,
    output logic [IDX_W-1:0]        o_mem_addr,
    output logic                    o_isect_en,
    output logic [0:1][0:2][31:0]   o_isect_ray,
    input  logic                    i_isect_valid,
    input  logic [31:0]             i_isect_t,
    input  logic                    i_isect_result,
    output logic                    o_hit_valid,
    input  logic                    i_hit_ready,
    output logic                    o_hit,
    output logic [31:0]             o_hit_t,
    output logic [IDX_W-1:0]        o_hit_idx,
    output logic                    o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_ray_ready;
    logic [0:1][0:2][31:0]   r_ray;
    logic [IDX_W-1:0]        r_base;
    logic [IDX_W-1:0]        r_count;
    logic [IDX_W-1:0]        r_issued;
    logic [IDX_W-1:0]        r_returned;
    logic                    r_mem_rd;
    logic [IDX_W-1:0]        r_mem_addr;
    logic                    r_hit_valid;
    logic                    r_best_hit;
    logic [31:0]             r_best_t;
    logic [IDX_W-1:0]        r_best_idx;
    logic [MEM_LAT-1:0]      r_en_sr;

    logic                    w_accept;
    logic                    w_ret_act;
    logic                    w_better;
    logic [IDX_W-1:0]        w_ret_idx;
    logic [IDX_W-1:0]        w_returned_inc;

    assign w_accept       = (r_state == S_IDLE) && r_ray_ready && i_ray_valid;
    // Returns only matter while a job is in flight; stray valids elsewhere are dropped.
    assign w_ret_act      = i_isect_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_ret_idx      = r_base + r_returned;
    assign w_returned_inc = r_returned + 1'b1;
    // Strict less-than keeps the earlier index when two hits share the same t.
    assign w_better       = i_isect_result &&
                            (!r_best_hit || ($signed(i_isect_t) < $signed(r_best_t)));

    // Read-strobe delay line: stage gi carries the strobe gi+1 cycles late,
    // so the last stage lines up with the memory read data.
    generate
        for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_en_sr
            if (gi == 0) begin : g_first
                // First stage samples the read strobe.
                always_ff @(posedge i_clk) begin
                    if (!i_rstn) r_en_sr[gi] <= 1'b0;
                    else         r_en_sr[gi] <= r_mem_rd;
                end
            end else begin : g_next
                // Later stages shift the strobe along.
                always_ff @(posedge i_clk) begin
                    if (!i_rstn) r_en_sr[gi] <= 1'b0;
                    else         r_en_sr[gi] <= r_en_sr[gi-1];
                end
            end
        end
    endgenerate

    // Job FSM: accept, issue reads, reduce returns, hold the result until taken.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_ray_ready <= 1'b0;
            r_ray       <= '0;
            r_base      <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_returned  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_hit_valid <= 1'b0;
            r_best_hit  <= 1'b0;
            r_best_t    <= '0;
            r_best_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ray_ready <= 1'b1;
                    if (w_accept) begin
                        r_ray_ready <= 1'b0;
                        r_ray       <= i_ray;
                        r_base      <= i_base;
                        r_count     <= i_count;
                        r_returned  <= '0;
                        r_best_hit  <= 1'b0;
                        r_best_t    <= '0;
                        r_best_idx  <= '0;
                        if (i_count == '0) begin
                            r_issued    <= '0;
                            r_hit_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            // First read goes out in the cycle right after accept.
                            r_issued    <= {{(IDX_W-1){1'b0}}, 1'b1};
                            r_mem_rd    <= 1'b1;
                            r_mem_addr  <= i_base;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // r_issued counts the read currently on the bus.
                    if (r_issued == r_count) begin
                        r_mem_rd <= 1'b0;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                        r_issued   <= r_issued + 1'b1;
                    end
                end
                S_DRAIN: begin
                end
                S_DONE: begin
                    if (i_hit_ready) begin
                        r_hit_valid <= 1'b0;
                        r_ray_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_ret_act) begin
                r_returned <= w_returned_inc;
                if (w_better) begin
                    r_best_hit <= 1'b1;
                    r_best_t   <= i_isect_t;
                    r_best_idx <= w_ret_idx;
                end
                // Memory latency keeps every return after the issue phase.
                if ((r_state == S_DRAIN) && (w_returned_inc == r_count)) begin
                    r_hit_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
            end
        end
    end

    assign o_ray_ready = r_ray_ready;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_addr  = r_mem_addr;
    assign o_isect_en  = r_en_sr[MEM_LAT-1];
    assign o_isect_ray = r_ray;
    assign o_hit_valid = r_hit_valid;
    assign o_hit       = r_best_hit;
    assign o_hit_t     = r_best_t;
    assign o_hit_idx   = r_best_idx;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: doc/isect_sched.md
# isect_sched

Sequences one ray against a contiguous range of triangles through the pipelined triangle-intersection unit and reduces the results to the closest hit. It sits between the ray dispatcher and the triangle memory / intersection pipeline. It issues one triangle per cycle, counts in-order returns, and outputs the nearest hit's t and triangle index.

## Interface
- IDX_W, 16, width of triangle index, address and count
- MEM_LAT, 2, fixed triangle-memory read latency in cycles (≥1); read data feeds the intersection unit's i_tri directly

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset i_rstn, synchronous, active-low; clock i_clk
- i_ray_valid  in  1  ray job offered
- o_ray_ready  out  1  job accepted when high with i_ray_valid
- i_ray  in  [0:1][0:2][31:0]  origin / direction, Q16.16
- i_base  in  IDX_W  first triangle index
- i_count  in  IDX_W  number of triangles (0 allowed)
- o_mem_rd  out  1  triangle read strobe
- o_mem_addr  out  IDX_W  triangle index to read
- o_isect_en  out  1  drives intersection i_en
- o_isect_ray  out  [0:1][0:2][31:0]  latched ray, drives intersection i_ray
- i_isect_valid  in  1  intersection o_valid
- i_isect_t  in  32  intersection o_t (signed Q16.16)
- i_isect_result  in  1  intersection o_result
- o_hit_valid  out  1  result available
- i_hit_ready  in  1  result consumed when high with o_hit_valid
- o_hit  out  1  at least one triangle hit
- o_hit_t  out  32  closest t (signed)
- o_hit_idx  out  IDX_W  index of closest triangle
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: o_ray_ready=1. On handshake, latch i_ray, i_base, i_count. Clear issued/returned counters and best (hit=0, t=0, idx=0). Go to DONE if i_count==0, else go to ISSUE.
- ISSUE: each cycle o_mem_rd=1, o_mem_addr=base+issued (mod 2^IDX_W), issued++. After the cycle issuing index count-1, go to DRAIN. There is no stall: the intersection unit accepts one triangle per cycle.
- o_isect_en = o_mem_rd delayed by exactly MEM_LAT cycles, implemented as a shift register cleared on reset.
- Returns are counted in ISSUE and DRAIN. Each i_isect_valid increments returned; its triangle index is base+returned (pre-increment, mod 2^IDX_W).
- Reduction per return: update best if i_isect_result && (!best_hit || i_isect_t < best_t), signed compare. On ties, keep the earlier index.
- DRAIN: go to DONE the cycle a return brings returned to count, including its reduction update.
- i_isect_valid is ignored in IDLE and DONE.
- DONE: o_hit_valid=1, with o_hit/o_hit_t/o_hit_idx held stable. On i_hit_ready, go to IDLE.
- o_isect_ray holds the latched ray from accept until the next accept.
- Reset mid-operation: state→IDLE; counters, enable shift register and best cleared. The intersection pipeline must share i_rstn so no stale return arrives afterwards.

## Timing
- Reset values: o_ray_ready=0 while i_rstn low, then 1 (IDLE). All other outputs 0.
- Ray handshake at edge N. o_mem_rd high in cycles N+1 … N+count. o_isect_en high in cycles N+1+MEM_LAT … N+count+MEM_LAT.
- With intersection latency L (i_en to o_valid), the last return occurs in cycle N+count+MEM_LAT+L. o_hit_valid rises the following cycle.
- count==0: o_hit_valid=1 in cycle N+1 with o_hit=0, o_hit_t=0, o_hit_idx=0.
- o_hit_valid is registered and stays high until the handshake. o_ray_ready rises in the cycle after the result handshake, giving one bubble between jobs.

## Test plan
- count=0, base=5 → no o_mem_rd pulses; o_hit_valid one cycle after accept, o_hit=0, o_hit_idx=0.
- base=10, count=4, returns t={3.0 hit, 1.5 hit, 0.5 miss, 2.0 hit} → addresses 10..13 on consecutive cycles; o_hit=1, o_hit_t=0x00018000, o_hit_idx=11.
- count=3, two hits with equal t=0x00020000 at idx 1 and 2 → o_hit_idx=base+1.
- base=0xFFFE, count=3 → o_mem_addr 0xFFFE, 0xFFFF, 0x0000; a hit only on the last return gives o_hit_idx=0x0000.
- i_hit_ready held low 10 cycles → outputs stable, o_ray_ready=0, no new reads; then ready=1 → IDLE the next cycle.
- i_rstn low during ISSUE → next cycle all outputs 0, o_isect_en cleared. After release, a new job with count=2 completes correctly with no contamination from the old job.
